// File: rtl/mac_learning_lut_if.sv
// Header-summary bus between the Ethernet parser stage and the learning MAC table.
//   master : parser side, drives the packet summary (dst_mac, src_mac, src_port,
//            eth_done) and the table_clear level; observes the lookup result.
//   slave  : the lookup table, returns dst_ports with lookup_done / lut_hit /
//            lut_miss and exposes the hit/miss counters.
interface mac_learning_lut_if #(
  parameter int NUM_QUEUES = 8
);
  logic [47:0]           dst_mac;
  logic [47:0]           src_mac;
  logic [NUM_QUEUES-1:0] src_port;
  logic                  eth_done;
  logic                  table_clear;
  logic [NUM_QUEUES-1:0] dst_ports;
  logic                  lookup_done;
  logic                  lut_hit;
  logic                  lut_miss;
  logic [31:0]           hit_count;
  logic [31:0]           miss_count;

  modport master (
    output dst_mac, src_mac, src_port, eth_done, table_clear,
    input  dst_ports, lookup_done, lut_hit, lut_miss, hit_count, miss_count
  );

  modport slave (
    input  dst_mac, src_mac, src_port, eth_done, table_clear,
    output dst_ports, lookup_done, lut_hit, lut_miss, hit_count, miss_count
  );
endinterface

// File: rtl/mac_learning_lut.sv
// Learning L2 forwarding table for the output_port_lookup datapath.
// Each eth_done request looks up dst_mac and learns src_mac -> src_port.
// The one-hot/flood destination vector appears two cycles later with lookup_done.
// Ports:
//   clk     : single clock
//   resetn  : asynchronous active-low reset
//   lut_if  : slave side of mac_learning_lut_if (request in, result and counters out)
module mac_learning_lut #(
  parameter int                    NUM_QUEUES     = 8,
  parameter int                    LUT_DEPTH      = 16,
  parameter int                    LUT_DEPTH_BITS = 4,
  parameter logic [NUM_QUEUES-1:0] FLOOD_MASK     = 8'h55
) (
  input logic              clk,
  input logic              resetn,
  mac_learning_lut_if.slave lut_if
);

  typedef logic [NUM_QUEUES-1:0]     port_t;
  typedef logic [LUT_DEPTH_BITS-1:0] idx_t;

  function automatic logic is_one_hot(input port_t p);
    return (p != '0) && ((p & (p - port_t'(1))) == '0);
  endfunction

  // Table storage: valid bits are control (reset), MAC/port are data (not reset)
  logic [LUT_DEPTH-1:0] tbl_valid_q, tbl_valid_d;
  logic [47:0]          tbl_mac_q  [LUT_DEPTH];
  logic [47:0]          tbl_mac_d  [LUT_DEPTH];
  port_t                tbl_port_q [LUT_DEPTH];
  port_t                tbl_port_d [LUT_DEPTH];
  idx_t                 rr_ptr_q, rr_ptr_d;

  logic        vld_p1_q, vld_p1_d;
  logic [47:0] dst_mac_p1_q, dst_mac_p1_d;
  logic [47:0] src_mac_p1_q, src_mac_p1_d;
  port_t       src_port_p1_q, src_port_p1_d;

  logic        vld_p2_q, vld_p2_d;
  logic        dst_hit_p2_q, dst_hit_p2_d;
  port_t       dst_port_p2_q, dst_port_p2_d;
  logic [47:0] src_mac_p2_q, src_mac_p2_d;
  port_t       src_port_p2_q, src_port_p2_d;
  logic        src_hit_p2_q, src_hit_p2_d;
  idx_t        src_idx_p2_q, src_idx_p2_d;
  logic        learn_ok_p2_q, learn_ok_p2_d;

  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  logic  wr_do;
  logic  wr_alloc;
  idx_t  wr_idx;
  logic  lut_hit;
  logic  lut_miss;
  port_t dst_ports;

  // ---- stage 0 -> 1: register the request ----
  always_comb begin
    vld_p1_d      = lut_if.eth_done;
    dst_mac_p1_d  = lut_if.dst_mac;
    src_mac_p1_d  = lut_if.src_mac;
    src_port_p1_d = lut_if.src_port;
  end

  // ---- stage 2: learn write decision ----
  // Decided against the table as it stands now, so an entry written by the
  // previous request (landed on this edge) is already accounted for.
  always_comb begin
    idx_t free_idx;
    logic tbl_full;
    free_idx = '0;
    tbl_full = 1'b1;
    for (int i = LUT_DEPTH - 1; i >= 0; i--) begin
      if (!tbl_valid_q[i]) begin
        free_idx = idx_t'(i);
        tbl_full = 1'b0;
      end
    end
    // table_clear wins over a coincident write, so no replacement happens either
    wr_do    = vld_p2_q && learn_ok_p2_q && !lut_if.table_clear;
    wr_alloc = !src_hit_p2_q;
    if (src_hit_p2_q)  wr_idx = src_idx_p2_q;
    else if (tbl_full) wr_idx = rr_ptr_q;
    else               wr_idx = free_idx;

    rr_ptr_d = rr_ptr_q;
    if (wr_do && wr_alloc && tbl_full) begin
      rr_ptr_d = (rr_ptr_q == idx_t'(LUT_DEPTH - 1)) ? '0 : rr_ptr_q + idx_t'(1);
    end

    tbl_valid_d = tbl_valid_q;
    tbl_mac_d   = tbl_mac_q;
    tbl_port_d  = tbl_port_q;
    if (wr_do) begin
      tbl_mac_d[wr_idx]  = src_mac_p2_q;
      tbl_port_d[wr_idx] = src_port_p2_q;
      if (wr_alloc) tbl_valid_d[wr_idx] = 1'b1;
    end
    if (lut_if.table_clear) tbl_valid_d = '0;
  end

  // ---- stage 1 -> 2: parallel compare ----
  // The stage-2 write of the previous request is folded into the compared view
  // so back-to-back requests behave as if processed strictly in order.
  always_comb begin
    logic        fwd;
    logic        e_valid;
    logic [47:0] e_mac;
    port_t       e_port;
    logic        dst_found;
    dst_found     = 1'b0;
    dst_port_p2_d = '0;
    src_hit_p2_d  = 1'b0;
    src_idx_p2_d  = '0;
    // descending scan so the lowest matching index is the one kept
    for (int i = LUT_DEPTH - 1; i >= 0; i--) begin
      fwd     = wr_do && (wr_idx == idx_t'(i));
      e_valid = tbl_valid_q[i] || (fwd && wr_alloc);
      e_mac   = fwd ? src_mac_p2_q  : tbl_mac_q[i];
      e_port  = fwd ? src_port_p2_q : tbl_port_q[i];
      if (e_valid && (e_mac == dst_mac_p1_q)) begin
        dst_found     = 1'b1;
        dst_port_p2_d = e_port;
      end
      if (e_valid && (e_mac == src_mac_p1_q)) begin
        src_hit_p2_d = 1'b1;
        src_idx_p2_d = idx_t'(i);
      end
    end
    vld_p2_d      = vld_p1_q;
    // group-addressed destinations are always flooded, even if present in the table
    dst_hit_p2_d  = dst_found && !dst_mac_p1_q[0];
    src_mac_p2_d  = src_mac_p1_q;
    src_port_p2_d = src_port_p1_q;
    learn_ok_p2_d = !src_mac_p1_q[0] && is_one_hot(src_port_p1_q);
  end

  // ---- stage 2: forwarding decision and counters ----
  always_comb begin
    lut_hit   = vld_p2_q && dst_hit_p2_q;
    lut_miss  = vld_p2_q && !dst_hit_p2_q;
    dst_ports = '0;
    if (lut_miss) begin
      dst_ports = FLOOD_MASK & ~src_port_p2_q;
    end else if (lut_hit && (dst_port_p2_q != src_port_p2_q)) begin
      dst_ports = dst_port_p2_q;
    end
    hit_count_d  = lut_hit  ? hit_count_q  + 32'd1 : hit_count_q;
    miss_count_d = lut_miss ? miss_count_q + 32'd1 : miss_count_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tbl_valid_q  <= '0;
      rr_ptr_q     <= '0;
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      tbl_valid_q  <= tbl_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      vld_p1_q     <= vld_p1_d;
      vld_p2_q     <= vld_p2_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  always_ff @(posedge clk) begin
    tbl_mac_q     <= tbl_mac_d;
    tbl_port_q    <= tbl_port_d;
    dst_mac_p1_q  <= dst_mac_p1_d;
    src_mac_p1_q  <= src_mac_p1_d;
    src_port_p1_q <= src_port_p1_d;
    dst_hit_p2_q  <= dst_hit_p2_d;
    dst_port_p2_q <= dst_port_p2_d;
    src_mac_p2_q  <= src_mac_p2_d;
    src_port_p2_q <= src_port_p2_d;
    src_hit_p2_q  <= src_hit_p2_d;
    src_idx_p2_q  <= src_idx_p2_d;
    learn_ok_p2_q <= learn_ok_p2_d;
  end

  assign lut_if.dst_ports   = dst_ports;
  assign lut_if.lookup_done = vld_p2_q;
  assign lut_if.lut_hit     = lut_hit;
  assign lut_if.lut_miss    = lut_miss;
  assign lut_if.hit_count   = hit_count_q;
  assign lut_if.miss_count  = miss_count_q;

endmodule
